// File: rtl/motor_ramp_sequencer.sv
// Motor ramp sequencer: ramps PWM duty in 10% steps toward a target. Every
// stop or reversal goes through duty 0 and a timed brake. Estop is synchronous.
module motor_ramp_sequencer #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned RAMP_STEP_MS = 100,
    parameter int unsigned BRAKE_MS     = 500,
    parameter int unsigned MAX_DUTY     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] target_duty,
    input  logic [1:0] dir_req,
    input  logic       estop,
    output logic [3:0] duty_cycle,
    output logic [1:0] in1_in2,
    output logic       motor_enable,
    output logic       busy,
    output logic [2:0] state
);
    localparam int unsigned STEP_CYC  = CLK_HZ / 1000 * RAMP_STEP_MS;
    localparam int unsigned BRAKE_CYC = CLK_HZ / 1000 * BRAKE_MS;
    localparam int unsigned STEP_W    = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int unsigned BRAKE_W   = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_CYC - 1);
    localparam logic [BRAKE_W-1:0] BRAKE_LAST = BRAKE_W'(BRAKE_CYC - 1);
    localparam logic [3:0]         DUTY_MAX   = 4'(MAX_DUTY);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP      = 3'd1,
        RUN       = 3'd2,
        RAMP_DOWN = 3'd3,
        BRAKE     = 3'd4
    } state_t;

    state_t               r_state;
    logic [3:0]           r_duty;
    logic [1:0]           r_in1_in2;
    logic [1:0]           r_active_dir;
    logic                 r_motor_en;
    logic                 r_busy;
    logic [STEP_W-1:0]    r_step_cnt;
    logic [BRAKE_W-1:0]   r_brake_cnt;

    logic [3:0] w_tgt;
    logic       w_go;
    logic       w_stop_req;
    logic       w_step_tick;

    assign w_tgt       = (target_duty > DUTY_MAX) ? DUTY_MAX : target_duty;
    assign w_go        = enable && (dir_req == 2'b10 || dir_req == 2'b01) && (w_tgt != 4'd0);
    assign w_stop_req  = !w_go || (dir_req != r_active_dir);
    assign w_step_tick = (r_step_cnt == STEP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_duty       <= '0;
            r_in1_in2    <= '0;
            r_active_dir <= '0;
            r_motor_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_step_cnt   <= '0;
            r_brake_cnt  <= '0;
        end else if (estop) begin
            // Brake counter is held at 0 while estop stays asserted.
            r_state     <= BRAKE;
            r_duty      <= '0;
            r_in1_in2   <= 2'b11;
            r_motor_en  <= 1'b0;
            r_busy      <= 1'b1;
            r_step_cnt  <= '0;
            r_brake_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_duty     <= '0;
                    r_step_cnt <= '0;
                    if (w_go) begin
                        r_active_dir <= dir_req;
                        r_in1_in2    <= dir_req;
                        r_motor_en   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= RAMP;
                    end else begin
                        r_in1_in2  <= 2'b00;
                        r_motor_en <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                RAMP: begin
                    if (w_stop_req) begin
                        r_state    <= RAMP_DOWN;
                        r_step_cnt <= '0;
                    end else if (r_duty == w_tgt) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b0;
                        r_step_cnt <= '0;
                    end else if (w_step_tick) begin
                        r_step_cnt <= '0;
                        r_duty     <= (w_tgt > r_duty) ? r_duty + 4'd1 : r_duty - 4'd1;
                    end else begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_step_cnt <= '0;
                    if (w_stop_req) begin
                        r_state <= RAMP_DOWN;
                        r_busy  <= 1'b1;
                    end else if (w_tgt != r_duty) begin
                        r_state <= RAMP;
                        r_busy  <= 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    // Runs to completion; a renewed go is only seen again in IDLE.
                    if (r_duty == 4'd0) begin
                        r_state     <= BRAKE;
                        r_in1_in2   <= 2'b11;
                        r_motor_en  <= 1'b0;
                        r_step_cnt  <= '0;
                        r_brake_cnt <= '0;
                    end else if (w_step_tick) begin
                        r_step_cnt <= '0;
                        r_duty     <= r_duty - 4'd1;
                    end else begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end
                end
                BRAKE: begin
                    r_duty <= '0;
                    if (r_brake_cnt == BRAKE_LAST) begin
                        r_state     <= IDLE;
                        r_in1_in2   <= 2'b00;
                        r_busy      <= 1'b0;
                        r_brake_cnt <= '0;
                    end else begin
                        r_brake_cnt <= r_brake_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_duty     <= '0;
                    r_in1_in2  <= 2'b00;
                    r_motor_en <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign duty_cycle   = r_duty;
    assign in1_in2      = r_in1_in2;
    assign motor_enable = r_motor_en;
    assign busy         = r_busy;
    assign state        = r_state;
endmodule

// File: doc/motor_ramp_sequencer.md
Name: motor_ramp_sequencer

Overview:
Sequencing controller that sits between the user-facing controls (debounced buttons, direction switches, timer enable) and the PWM duty-cycle datapath and H-bridge IN1/IN2 pins of the DC-motor design. It ramps the duty cycle one 10% step at a time toward a requested target. It forces a ramp-down and timed brake before any direction reversal or stop, and provides a synchronous emergency stop. Its outputs drive the PWM block's duty/enable inputs and the in1_in2 pins.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz
RAMP_STEP_MS, 100, dwell time per 10% duty step; STEP_CYC = CLK_HZ/1000*RAMP_STEP_MS
BRAKE_MS, 500, brake hold time; BRAKE_CYC = CLK_HZ/1000*BRAKE_MS
MAX_DUTY, 10, duty ceiling in 10% units

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
enable  in  1  run request (1 = motor may run; e.g. timer_running or constant 1)
target_duty  in  4  requested duty in 10% units; values > MAX_DUTY are clamped to MAX_DUTY
dir_req  in  2  requested {in1,in2}: 10 fwd, 01 rev, 11 brake, 00 coast
estop  in  1  synchronous emergency stop, level-sensitive
duty_cycle  out  4  duty to PWM block, 0..MAX_DUTY
in1_in2  out  2  H-bridge direction pins
motor_enable  out  1  PWM output enable
busy  out  1  high in RAMP, RAMP_DOWN and BRAKE
state  out  3  IDLE=0, RAMP=1, RUN=2, RAMP_DOWN=3, BRAKE=4 (debug/LED)

Behaviour:
- All outputs are registered. Reset (rst=1 at a clk edge) overrides everything: state=IDLE, duty_cycle=0, in1_in2=00, motor_enable=0, busy=0, both counters=0, active_dir=00. Reset mid-ramp aborts immediately with no brake phase.
- tgt = min(target_duty, MAX_DUTY). go = enable & (dir_req==10 | dir_req==01) & tgt!=0.
- Step counter: counts 0..STEP_CYC-1 in RAMP/RAMP_DOWN and clears on every state change. step_tick = (cnt==STEP_CYC-1). The first step therefore occurs STEP_CYC cycles after entry.
- IDLE: duty=0, in1_in2=00, motor_enable=0. If go: active_dir<=dir_req, in1_in2<=dir_req, go to RAMP on the next edge.
- RAMP: motor_enable=1, in1_in2=active_dir. On step_tick, duty moves ±1 toward tgt. When duty==tgt (checked every cycle), go to RUN. If go drops or dir_req!=active_dir, go to RAMP_DOWN. Target changes mid-ramp are followed, including reversing the ramp direction.
- RUN: duty held. tgt!=duty with go still true -> RAMP. !go or dir_req!=active_dir -> RAMP_DOWN.
- RAMP_DOWN: in1_in2=active_dir, motor_enable=1. On step_tick, duty-=1. When duty==0, go to BRAKE. A renewed go here is ignored; the sequence completes first.
- BRAKE: in1_in2=11, duty=0, motor_enable=0. Brake counter counts BRAKE_CYC cycles, then the block enters IDLE. IDLE re-evaluates go, so a pending reversal restarts as RAMP in the opposite direction.
- estop: highest priority below rst. On any edge with estop=1: state<=BRAKE, duty<=0, in1_in2<=11, motor_enable<=0, brake counter<=0. While estop stays high the counter is held at 0. The BRAKE_CYC timeout starts on the first cycle estop is low.
- A direction change always passes through duty 0 and BRAKE. in1_in2 never goes directly 10<->01.
- Simultaneous events in one cycle resolve by priority: rst > estop > direction/enable change > target change.

Test Plan:
Use CLK_HZ=1000, RAMP_STEP_MS=4, BRAKE_MS=8 (STEP_CYC=4, BRAKE_CYC=8) for all scenarios.
1. Reset, then enable=1, dir_req=10, target=3 -> next edge in1_in2=10, RAMP; duty 1/2/3 at +4/+8/+12 cycles; RUN with busy=0 one cycle later.
2. In RUN at duty 3, set target=15 -> clamp to 10; duty reaches 10 after 7 steps (28 cycles) and never exceeds 10. Then target=6 -> duty ramps down to 6 and returns to RUN.
3. In RUN at 10, dir_req=10 -> 01 -> RAMP_DOWN to 0 in 40 cycles, in1_in2 stays 10; BRAKE with in1_in2=11 for 8 cycles; IDLE; then RAMP with in1_in2=01. No cycle ever shows 10 directly followed by 01.
4. estop pulsed for 3 cycles mid-ramp at duty 5 -> next edge duty=0, in1_in2=11, motor_enable=0; IDLE reached exactly 8 cycles after estop falls.
5. rst asserted in RAMP_DOWN at duty 4 -> next edge all outputs at reset values, state=IDLE, no BRAKE phase.
6. enable=0 during RAMP at duty 2 (target 8) -> RAMP_DOWN, duty 1 then 0, BRAKE, IDLE. Re-asserting enable during RAMP_DOWN is ignored until IDLE.
